// File: rtl/fp_tap_accumulator.sv
// Accumulates TAPS single-precision products per window through an external
// combinational FP adder, then presents the window sum with sticky flags.
module fp_tap_accumulator #(
    parameter int TAPS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_s,
    input  logic        add_ovf,
    input  logic        add_unf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_unf
);

    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

    typedef enum logic {
        ACCUM,
        OUT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     acc;
    logic [31:0]     acc_next;
    logic [CW-1:0]   tap_cnt;
    logic            ovf_s;
    logic            unf_s;
    logic            ovf_next;
    logic            unf_next;
    logic            accept;
    logic            last_tap;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign add_a     = acc;
    assign add_b     = in_data;
    assign accept    = in_valid && in_ready;
    assign last_tap  = (tap_cnt == LAST_TAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (clr) begin
            state_next = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && last_tap) state_next = OUT;
                OUT:     if (out_ready) state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    // Zero taps are skipped and a zero accumulator is replaced, so the adder
    // (and its flags) only ever sees two non-zero operands.
    always_comb begin
        acc_next = acc;
        ovf_next = ovf_s;
        unf_next = unf_s;
        if (tap_cnt == '0) begin
            acc_next = in_data;
            ovf_next = 1'b0;
            unf_next = 1'b0;
        end else if (in_data[30:0] == 31'd0) begin
            acc_next = acc;
        end else if (acc[30:0] == 31'd0) begin
            acc_next = in_data;
        end else begin
            acc_next = add_s;
            ovf_next = ovf_s | add_ovf;
            unf_next = unf_s | add_unf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= 32'h0000_0000;
            tap_cnt  <= '0;
            ovf_s    <= 1'b0;
            unf_s    <= 1'b0;
            out_data <= 32'h0000_0000;
            out_ovf  <= 1'b0;
            out_unf  <= 1'b0;
        end else if (clr) begin
            acc     <= 32'h0000_0000;
            tap_cnt <= '0;
            ovf_s   <= 1'b0;
            unf_s   <= 1'b0;
        end else if (accept) begin
            acc     <= acc_next;
            ovf_s   <= ovf_next;
            unf_s   <= unf_next;
            tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
            if (last_tap) begin
                out_data <= acc_next;
                out_ovf  <= ovf_next;
                out_unf  <= unf_next;
            end
        end
    end

endmodule

// File: tb/tb_fp_tap_accumulator.sv
// Self-checking bench: an FP adder stub plus a window-level reference model
// compared against the DUT on every falling edge, with directed literal checks.
module tb_fp_tap_accumulator;

    localparam int TAPS = 9;
    localparam logic [31:0] ONE = 32'h3F80_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_s;
    logic        add_ovf = 1'b0;
    logic        add_unf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_unf;

    logic        t1_in_valid = 1'b0;
    logic        t1_in_ready;
    logic [31:0] t1_in_data = 32'h0;
    logic [31:0] t1_add_a;
    logic [31:0] t1_add_b;
    logic        t1_out_valid;
    logic [31:0] t1_out_data;
    logic        t1_out_ovf;
    logic        t1_out_unf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_tap_accumulator #(.TAPS(TAPS)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .add_ovf(add_ovf), .add_unf(add_unf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_unf(out_unf)
    );

    fp_tap_accumulator #(.TAPS(1)) dut1 (
        .clk(clk), .rst(rst), .clr(1'b0),
        .in_valid(t1_in_valid), .in_ready(t1_in_ready), .in_data(t1_in_data),
        .add_a(t1_add_a), .add_b(t1_add_b), .add_s(32'h0000_0000),
        .add_ovf(1'b1), .add_unf(1'b1),
        .out_valid(t1_out_valid), .out_ready(1'b1), .out_data(t1_out_data),
        .out_ovf(t1_out_ovf), .out_unf(t1_out_unf)
    );

    function automatic real to_real(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        for (int i = 0; i < e; i++) m = m * 2.0;
        for (int i = 0; i > e; i--) m = m / 2.0;
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] to_single(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return to_single(to_real(a) + to_real(b));
    endfunction

    // Exact for the small integer-valued operands used throughout.
    always_comb add_s = fp_add(add_a, add_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects each window's taps and folds them on completion.
    logic [31:0] win_tap[$];
    logic        win_ovf[$];
    logic        win_unf[$];
    logic        m_pending = 1'b0;
    logic [31:0] m_data = 32'h0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    task automatic fold_window();
        logic [31:0] a;
        logic        o;
        logic        u;
        a = win_tap[0];
        o = 1'b0;
        u = 1'b0;
        for (int i = 1; i < win_tap.size(); i++) begin
            if (win_tap[i][30:0] == 31'd0) continue;
            if (a[30:0] == 31'd0) begin
                a = win_tap[i];
            end else begin
                a = fp_add(a, win_tap[i]);
                o = o | win_ovf[i];
                u = u | win_unf[i];
            end
        end
        m_data = a;
        m_ovf  = o;
        m_unf  = u;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst || clr) begin
                m_pending = 1'b0;
                win_tap.delete();
                win_ovf.delete();
                win_unf.delete();
            end else if (!m_pending) begin
                if (in_valid) begin
                    win_tap.push_back(in_data);
                    win_ovf.push_back(add_ovf);
                    win_unf.push_back(add_unf);
                    if (win_tap.size() == TAPS) begin
                        fold_window();
                        m_pending = 1'b1;
                        win_tap.delete();
                        win_ovf.delete();
                        win_unf.delete();
                    end
                end
            end else if (out_ready) begin
                m_pending = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_in_ready", 32'(in_ready), 32'(!m_pending));
            check("cmp_out_valid", 32'(out_valid), 32'(m_pending));
            if (m_pending) begin
                check("cmp_out_data", out_data, m_data);
                check("cmp_out_ovf", 32'(out_ovf), 32'(m_ovf));
                check("cmp_out_unf", 32'(out_unf), 32'(m_unf));
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic ov,
                         input logic un, input logic ordy, input logic c);
        in_valid  = v;
        in_data   = d;
        add_ovf   = ov;
        add_unf   = un;
        out_ready = ordy;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [31:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic ones(input int n);
        for (int i = 0; i < n; i++) tap(ONE);
    endtask

    function automatic logic [31:0] rand_val();
        int k;
        k = int'($urandom_range(0, 19));
        if (k == 17) return 32'h8000_0000;
        if (k >= 18) return 32'h0000_0000;
        return to_single(real'(k - 8));
    endfunction

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        check("pin_add_1_1", fp_add(ONE, ONE), 32'h4000_0000);
        check("pin_add_3_m5", fp_add(32'h4040_0000, 32'hC0A0_0000), 32'hC000_0000);
        check("pin_add_cancel", fp_add(32'h4040_0000, 32'hC040_0000), 32'h0000_0000);

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_out_ovf", 32'(out_ovf), 32'd0);
        check("reset_out_unf", 32'(out_unf), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Nine ones back-to-back
        ones(9);
        check("nine_valid", 32'(out_valid), 32'd1);
        check("nine_data", out_data, 32'h4110_0000);
        check("nine_ovf", 32'({out_ovf, out_unf}), 32'd0);
        check("nine_in_ready_low", 32'(in_ready), 32'd0);
        idle();
        check("nine_in_ready_back", 32'(in_ready), 32'd1);
        check("nine_valid_drop", 32'(out_valid), 32'd0);

        // Zero bypass
        tap(32'h0000_0000);
        tap(32'h4000_0000);
        tap(32'h8000_0000);
        ones(6);
        check("bypass_data", out_data, 32'h4100_0000);
        check("bypass_flags", 32'({out_ovf, out_unf}), 32'd0);
        idle();

        // Backpressure: outputs hold, taps ignored
        ones(9);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 1'b0);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, 32'h4110_0000);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        idle();
        ones(9);
        check("after_hold_data", out_data, 32'h4110_0000);
        idle();

        // Overflow stub on tap 4 only
        ones(4);
        drive(1'b1, ONE, 1'b1, 1'b0, 1'b1, 1'b0);
        ones(4);
        check("ovf_set", 32'(out_ovf), 32'd1);
        idle();
        ones(9);
        check("ovf_cleared", 32'(out_ovf), 32'd0);
        idle();

        // Reset mid-window
        ones(5);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ones(9);
        check("rst_mid_data", out_data, 32'h4110_0000);
        idle();

        // Clear coincident with tap 5
        ones(4);
        drive(1'b1, ONE, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_no_valid", 32'(out_valid), 32'd0);
        ones(8);
        check("clr_not_early", 32'(out_valid), 32'd0);
        tap(ONE);
        check("clr_data", out_data, 32'h4110_0000);
        idle();

        // TAPS = 1 pass-through
        t1_in_valid = 1'b1;
        t1_in_data  = 32'hC049_0FDB;
        @(posedge clk);
        #1;
        t1_in_valid = 1'b0;
        check("t1_valid", 32'(t1_out_valid), 32'd1);
        check("t1_data", t1_out_data, 32'hC049_0FDB);
        check("t1_flags", 32'({t1_out_ovf, t1_out_unf}), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, rand_val(), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 59) == 0);
        end
        begin
            int n;
            n = 0;
            while (out_valid && n < 20) begin
                idle();
                n++;
            end
            check("drain_done", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_tap_accumulator.md
FP_TAP_ACCUMULATOR -- requirements
Module: fp_tap_accumulator

Interface
REQ-001 SHALL have parameter TAPS, default 9; number of IEEE-754 single-precision products summed per output window (legal range 1..64).
REQ-002 SHALL have ports in this order:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort of the current window.
- in_valid  input  1  product word valid.
- in_ready  output  1  block can accept a product.
- in_data  input  32  IEEE-754 single product (sign, exp[30:23], mant[22:0]).
- add_a  output  32  operand A to external combinational FP adder.
- add_b  output  32  operand B to external combinational FP adder.
- add_s  input  32  adder sum.
- add_ovf  input  1  adder overflow flag.
- add_unf  input  1  adder underflow flag.
- out_valid  output  1  window sum valid.
- out_ready  input  1  downstream accepts the sum.
- out_data  output  32  window sum.
- out_ovf  output  1  sticky overflow over the window.
- out_unf  output  1  sticky underflow over the window.
REQ-003 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-004 SHALL implement FSM states ACCUM and OUT; reset state ACCUM.
REQ-005 SHALL assert in_ready = 1 in ACCUM and 0 in OUT; a tap is accepted when in_valid && in_ready on a rising edge.
REQ-006 SHALL hold internal registers acc[31:0], tap_cnt (0..TAPS-1), ovf_s, unf_s.
REQ-007 SHALL drive add_a = acc and add_b = in_data combinationally at all times; the adder result is sampled only on an accepted tap.
REQ-008 SHALL, on accepted tap with tap_cnt == 0: acc <= in_data, ovf_s <= 0, unf_s <= 0 (no add).
REQ-009 SHALL, on accepted tap with tap_cnt > 0: if in_data[30:0] == 0, acc unchanged; else if acc[30:0] == 0, acc <= in_data; else acc <= add_s, ovf_s |= add_ovf, unf_s |= add_unf.
REQ-010 SHALL treat zero bypass (REQ-009) as leaving the sticky flags unchanged.
REQ-011 SHALL increment tap_cnt on each accepted tap; on accepting tap TAPS-1 it SHALL reset tap_cnt to 0 and move to OUT on the same edge.
REQ-012 SHALL register out_data, out_ovf, out_unf on the transition to OUT: final acc value and final sticky flags, including the last tap's contribution.
REQ-013 SHALL assert out_valid = 1 only in OUT; latency from the last-tap acceptance edge to out_valid high is 1 cycle.
REQ-014 SHALL hold out_data, out_ovf, out_unf stable while out_valid && !out_ready.
REQ-015 SHALL return to ACCUM on the edge where out_valid && out_ready; out_valid drops the following cycle; minimum period is TAPS+1 cycles per window.
REQ-016 SHALL, when clr = 1 at an edge, force tap_cnt = 0, acc = 0, sticky flags = 0, state = ACCUM, and out_valid = 0; clr has priority over a simultaneous tap acceptance or output handshake, and the tap or result is discarded.
REQ-017 SHALL, with TAPS = 1, pass each accepted in_data directly to out_data, with flags 0.
REQ-018 SHALL NOT inspect NaN/Inf encodings; they pass through the adder path unchanged.

Reset
REQ-019 SHALL, while rst = 1, set state = ACCUM, tap_cnt = 0, and acc, out_data = 32'h00000000; ovf_s, unf_s, out_ovf, out_unf, out_valid = 0; in_ready = 1 after deassertion.
REQ-020 SHALL discard any partial window on rst assertion mid-window; the first tap after reset starts a new window.

Verification
REQ-021 Nine taps of 32'h3F800000 back-to-back, out_ready=1 -> out_valid at cycle 10, out_data 32'h41100000 (9.0), flags 0, in_ready low for exactly 1 cycle.
REQ-022 Taps 0x00000000, 0x40000000, 0x80000000, then six taps of 0x3F800000 -> zero bypass gives out_data 32'h41000000 (8.0).
REQ-023 Complete window, hold out_ready=0 for 5 cycles -> out_valid, out_data, and flags are stable, in_ready=0, and in_valid taps are ignored; out_ready=1 -> next window starts.
REQ-024 Stub add_ovf=1 on tap 4 only -> out_ovf=1 for that window; next window out_ovf=0.
REQ-025 Assert rst after tap 5, then feed 9 taps of 1.0 -> out_data 9.0; repeat with clr pulsed coincident with tap 5 -> that tap is dropped, and the next 9 taps produce 9.0.
REQ-026 TAPS=1 build, in_data 32'hC0490FDB -> out_data 32'hC0490FDB one cycle later.
